// File: rtl/cdb_broadcaster.sv
// Common data bus broadcaster: arbitrates round-robin among per-FU holding registers, one result per cycle.
// Latency: a result accepted at edge k is broadcast (registered) at edge k+1 at the earliest.
// Backpressure: fu_ready[i] drops while port i holds an ungranted result, during squash, and during reset.
//
// Ports:
//   clock, reset (async active-low), squash (synchronous flush of held results)
//   fu_valid/fu_tag/fu_value/fu_ready : per-FU completion handshake (tag 0 is accepted but dropped)
//   cdb_valid/cdb_reg_tag/cdb_reg_value/cdb_fu_idx : registered broadcast; idle bus shows all zeros
module cdb_broadcaster #(
  parameter int NUM_FU = 4,
  parameter int TAG_W  = 5,
  parameter int XLEN   = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              squash,
  input  logic [NUM_FU-1:0]                 fu_valid,
  input  logic [NUM_FU-1:0][TAG_W-1:0]      fu_tag,
  input  logic [NUM_FU-1:0][XLEN-1:0]       fu_value,
  output logic [NUM_FU-1:0]                 fu_ready,
  output logic                              cdb_valid,
  output logic [TAG_W-1:0]                  cdb_reg_tag,
  output logic [XLEN-1:0]                   cdb_reg_value,
  output logic [$clog2(NUM_FU)-1:0]         cdb_fu_idx
);

  localparam int IDX_W = $clog2(NUM_FU);

  // Holding registers, one entry per port.
  logic [NUM_FU-1:0]                held;
  logic [NUM_FU-1:0][TAG_W-1:0]     held_tag;
  logic [NUM_FU-1:0][XLEN-1:0]      held_value;
  logic [NUM_FU-1:0]                held_cnt;     // number of set bits in held
  logic [IDX_W-1:0]                 ptr;          // round-robin start position

  logic                             gnt_vld;
  logic [IDX_W-1:0]                 gnt_idx;
  logic [NUM_FU-1:0]                grant;
  logic [IDX_W-1:0]                 cand;
  logic [NUM_FU-1:0]                accept;
  logic [NUM_FU-1:0]                held_nxt;
  logic [NUM_FU-1:0]                held_cnt_nxt;

  // (base + off) mod NUM_FU, valid for any NUM_FU, not just powers of two.
  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    return IDX_W'(s % NUM_FU);
  endfunction

  // Round-robin arbiter: first held port at or after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    cand    = '0;
    if (held_cnt != '0 && !squash) begin
      for (int j = 0; j < NUM_FU; j++) begin
        cand = wrap_idx(ptr, j);
        if (!gnt_vld && held[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
    if (gnt_vld) begin
      grant[gnt_idx] = 1'b1;
    end
  end

  // A granted port frees its slot this cycle, so it can take a new result
  // in the same cycle without a bubble.
  assign fu_ready = {NUM_FU{reset & ~squash}} & (~held | grant);

  always_comb begin
    held_cnt_nxt = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      // Tag 0 completes the handshake but never occupies the slot.
      accept[i] = fu_valid[i] & fu_ready[i] & (fu_tag[i] != '0);
    end
    held_nxt = (held & ~grant) | accept;
    for (int i = 0; i < NUM_FU; i++) begin
      held_cnt_nxt = held_cnt_nxt + NUM_FU'(held_nxt[i]);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      held          <= '0;
      held_tag      <= '0;
      held_value    <= '0;
      held_cnt      <= '0;
      ptr           <= '0;
      cdb_valid     <= 1'b0;
      cdb_reg_tag   <= '0;
      cdb_reg_value <= '0;
      cdb_fu_idx    <= '0;
    end else if (squash) begin
      // Flush everything held; the pointer keeps its position.
      held          <= '0;
      held_cnt      <= '0;
      cdb_valid     <= 1'b0;
      cdb_reg_tag   <= '0;
      cdb_reg_value <= '0;
      cdb_fu_idx    <= '0;
    end else begin
      held     <= held_nxt;
      held_cnt <= held_cnt_nxt;
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i]) begin
          held_tag[i]   <= fu_tag[i];
          held_value[i] <= fu_value[i];
        end
      end
      if (gnt_vld) begin
        ptr           <= wrap_idx(gnt_idx, 1);
        cdb_valid     <= 1'b1;
        cdb_reg_tag   <= held_tag[gnt_idx];
        cdb_reg_value <= held_value[gnt_idx];
        cdb_fu_idx    <= gnt_idx;
      end else begin
        cdb_valid     <= 1'b0;
        cdb_reg_tag   <= '0;
        cdb_reg_value <= '0;
        cdb_fu_idx    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Testbench for cdb_broadcaster: directed scenarios with literal expectations plus randomized traffic.
// Latency: checks registered broadcast one edge after acceptance.
// Backpressure: compares fu_ready every cycle against the reference model.
module tb_cdb_broadcaster;
  localparam int NUM_FU = 4;
  localparam int TAG_W  = 5;
  localparam int XLEN   = 32;

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic                         squash = 1'b0;
  logic [NUM_FU-1:0]            fu_valid = '0;
  logic [NUM_FU-1:0][TAG_W-1:0] fu_tag = '0;
  logic [NUM_FU-1:0][XLEN-1:0]  fu_value = '0;
  logic [NUM_FU-1:0]            fu_ready;
  logic                         cdb_valid;
  logic [TAG_W-1:0]             cdb_reg_tag;
  logic [XLEN-1:0]              cdb_reg_value;
  logic [1:0]                   cdb_fu_idx;

  cdb_broadcaster #(.NUM_FU(NUM_FU), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value), .fu_ready(fu_ready),
    .cdb_valid(cdb_valid), .cdb_reg_tag(cdb_reg_tag), .cdb_reg_value(cdb_reg_value),
    .cdb_fu_idx(cdb_fu_idx)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: per-port slot contents, rotating start position and expected bus.
  bit          m_held [NUM_FU];
  int          m_tag  [NUM_FU];
  logic [31:0] m_val  [NUM_FU];
  int          m_ptr;
  bit          e_vld;
  int          e_tag;
  logic [31:0] e_val;
  int          e_idx;

  function automatic int m_winner();
    for (int j = 0; j < NUM_FU; j++) begin
      if (m_held[(m_ptr + j) % NUM_FU]) return (m_ptr + j) % NUM_FU;
    end
    return -1;
  endfunction

  always @(posedge clock or negedge reset) begin
    int  g;
    bit  rdy [NUM_FU];
    if (!reset) begin
      for (int i = 0; i < NUM_FU; i++) m_held[i] = 0;
      m_ptr = 0; e_vld = 0; e_tag = 0; e_val = 0; e_idx = 0;
    end else if (squash) begin
      for (int i = 0; i < NUM_FU; i++) m_held[i] = 0;
      e_vld = 0; e_tag = 0; e_val = 0; e_idx = 0;
    end else begin
      g = m_winner();
      for (int i = 0; i < NUM_FU; i++) rdy[i] = !m_held[i] || (i == g);
      if (g >= 0) begin
        e_vld = 1; e_tag = m_tag[g]; e_val = m_val[g]; e_idx = g;
        m_held[g] = 0;
        m_ptr = (g + 1) % NUM_FU;
      end else begin
        e_vld = 0; e_tag = 0; e_val = 0; e_idx = 0;
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (fu_valid[i] && rdy[i] && fu_tag[i] != 0) begin
          m_held[i] = 1;
          m_tag[i]  = int'(fu_tag[i]);
          m_val[i]  = fu_value[i];
        end
      end
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clock) begin
    int g;
    logic [NUM_FU-1:0] exp_rdy;
    if (chk_en) begin
      g = m_winner();
      for (int i = 0; i < NUM_FU; i++)
        exp_rdy[i] = reset && !squash && (!m_held[i] || g == i);
      chk("m_cdb_valid", 64'(cdb_valid), 64'(e_vld));
      chk("m_cdb_tag", 64'(cdb_reg_tag), 64'(e_tag));
      chk("m_cdb_value", 64'(cdb_reg_value), 64'(e_val));
      chk("m_cdb_idx", 64'(cdb_fu_idx), 64'(e_idx));
      chk("m_fu_ready", 64'(fu_ready), 64'(exp_rdy));
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle_in();
    fu_valid = '0; fu_tag = '0; fu_value = '0; squash = 1'b0;
  endtask

  task automatic offer(input int p, input int t, input int v);
    fu_valid[p] = 1'b1;
    fu_tag[p]   = TAG_W'(t);
    fu_value[p] = XLEN'(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_ready", 64'(fu_ready), 64'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("rst_ready_rel", 64'(fu_ready), 64'hF);
    chk("rst_valid", 64'(cdb_valid), 64'h0);
  endtask

  initial begin
    #1 reset = 1'b0;
    chk_en = 1;
    #1;
    chk("rst_cdb_valid", 64'(cdb_valid), 64'h0);
    chk("rst_cdb_tag", 64'(cdb_reg_tag), 64'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("ready_after_rst", 64'(fu_ready), 64'hF);

    // Contention: four ports at once, broadcast in port order from ptr 0.
    for (int p = 0; p < 4; p++) offer(p, 4 + p, 40 + 10 * p);
    tick();
    idle_in();
    chk("cont_first_idle", 64'(cdb_valid), 64'h0);
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("cont_valid", 64'(cdb_valid), 64'h1);
      chk("cont_tag", 64'(cdb_reg_tag), 64'(4 + n));
      chk("cont_idx", 64'(cdb_fu_idx), 64'(n));
    end
    tick();
    chk("cont_end_idle", 64'(cdb_valid), 64'h0);
    // Pointer back at 0: port 0 wins over port 3.
    offer(0, 11, 1); offer(3, 12, 2);
    tick(); idle_in();
    tick();
    chk("ptr0_tag", 64'(cdb_reg_tag), 64'd11);
    tick();
    chk("ptr0_tag2", 64'(cdb_reg_tag), 64'd12);
    chk("ptr0_idx2", 64'(cdb_fu_idx), 64'd3);
    tick();

    // Single result on port 1.
    offer(1, 3, 10);
    tick(); idle_in();
    chk("single_k", 64'(cdb_valid), 64'h0);
    tick();
    chk("single_valid", 64'(cdb_valid), 64'h1);
    chk("single_tag", 64'(cdb_reg_tag), 64'd3);
    chk("single_value", 64'(cdb_reg_value), 64'd10);
    chk("single_idx", 64'(cdb_fu_idx), 64'd1);
    tick();
    chk("single_idle_v", 64'(cdb_valid), 64'h0);
    chk("single_idle_t", 64'(cdb_reg_tag), 64'h0);

    // Fairness: port 0 continuous, port 2 once, from ptr 0.
    do_reset();
    offer(0, 8, 80); offer(2, 20, 200);
    tick();
    fu_valid[2] = 1'b0;
    tick();
    chk("fair_idx1", 64'(cdb_fu_idx), 64'd0);
    chk("fair_rdy0_blocked", 64'(fu_ready[0]), 64'h0);
    tick();
    chk("fair_idx2", 64'(cdb_fu_idx), 64'd2);
    chk("fair_tag2", 64'(cdb_reg_tag), 64'd20);
    tick();
    chk("fair_idx3", 64'(cdb_fu_idx), 64'd0);
    chk("fair_valid3", 64'(cdb_valid), 64'h1);
    idle_in();
    repeat (3) tick();

    // Back-to-back on port 3.
    for (int n = 1; n <= 3; n++) begin
      offer(3, n, 100 + n);
      #1;
      chk("b2b_ready", 64'(fu_ready[3]), 64'h1);
      tick();
      if (n >= 2) chk("b2b_tag", 64'(cdb_reg_tag), 64'(n - 1));
    end
    idle_in();
    tick();
    chk("b2b_tag3", 64'(cdb_reg_tag), 64'd3);
    chk("b2b_val3", 64'(cdb_reg_value), 64'd103);
    tick();
    chk("b2b_idle", 64'(cdb_valid), 64'h0);

    // Tag 0 is accepted but never broadcast.
    offer(0, 0, 99);
    #1;
    chk("tag0_ready", 64'(fu_ready[0]), 64'h1);
    tick(); idle_in();
    repeat (2) begin
      tick();
      chk("tag0_novalid", 64'(cdb_valid), 64'h0);
    end

    // Squash with two results held.
    offer(1, 13, 130); offer(2, 14, 140);
    tick(); idle_in();
    squash = 1'b1;
    #1;
    chk("squash_ready", 64'(fu_ready), 64'h0);
    tick();
    squash = 1'b0;
    repeat (2) begin
      chk("squash_novalid", 64'(cdb_valid), 64'h0);
      tick();
    end

    // Reset asserted mid-cycle while results are held and one is on the bus.
    offer(1, 15, 150); offer(2, 16, 160);
    tick(); idle_in();
    tick();
    chk("mrst_pre_tag", 64'(cdb_reg_tag), 64'd15);
    chk("mrst_pre_idx", 64'(cdb_fu_idx), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("mrst_valid", 64'(cdb_valid), 64'h0);
    chk("mrst_tag", 64'(cdb_reg_tag), 64'h0);
    chk("mrst_value", 64'(cdb_reg_value), 64'h0);
    chk("mrst_idx", 64'(cdb_fu_idx), 64'h0);
    chk("mrst_ready", 64'(fu_ready), 64'h0);
    #3 reset = 1'b1;
    repeat (2) begin
      tick();
      chk("mrst_after", 64'(cdb_valid), 64'h0);
    end

    // Randomized traffic, with occasional squash and mid-cycle reset.
    repeat (3000) begin
      for (int i = 0; i < NUM_FU; i++) begin
        fu_valid[i] = ($urandom_range(0, 2) != 0);
        fu_tag[i]   = TAG_W'($urandom_range(0, 31));
        fu_value[i] = $urandom;
      end
      squash = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset = 1'b0;
        #1 reset = 1'b1;
      end
      tick();
    end
    idle_in();
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_broadcaster.md
CDB_BROADCASTER -- requirements
Module: cdb_broadcaster

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, giving the number of functional-unit completion ports (2..8).
REQ-002 SHALL have parameter TAG_W, default 5, giving the ROB tag width; tag 0 means "no tag / register file".
REQ-003 SHALL have parameter XLEN, default 32, giving the result value width.
REQ-004 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port squash  in  1  synchronous flush of all held results.
REQ-007 SHALL have port fu_valid  in  NUM_FU  per-port completion request.
REQ-008 SHALL have port fu_tag  in  NUM_FU x TAG_W  per-port ROB tag of the completed instruction.
REQ-009 SHALL have port fu_value  in  NUM_FU x XLEN  per-port result value.
REQ-010 SHALL have port fu_ready  out  NUM_FU  per-port acceptance; a transfer occurs when fu_valid and fu_ready are both 1 at a rising edge.
REQ-011 SHALL have port cdb_valid  out  1  broadcast valid this cycle.
REQ-012 SHALL have port cdb_reg_tag  out  TAG_W  broadcast tag.
REQ-013 SHALL have port cdb_reg_value  out  XLEN  broadcast value.
REQ-014 SHALL have port cdb_fu_idx  out  clog2(NUM_FU)  index of the port whose result is on the bus.

Function
REQ-015 SHALL hold one result per port in a holding register: held[i], tag, value.
REQ-016 SHALL drive fu_ready[i] = !squash && (!held[i] || grant[i]), so a port holding a result that is granted this cycle accepts a new result in the same cycle.
REQ-017 SHALL complete a transfer with fu_tag == 0 (fu_ready unaffected) but SHALL discard it: held[i] is not set.
REQ-018 SHALL arbitrate combinationally each cycle among the ports with held[i] = 1, using a round-robin pointer ptr: the first held port at or after ptr, taken modulo NUM_FU, wins.
REQ-019 SHALL grant at most one port per cycle; on a grant to port g, at the edge: held[g] clears (unless refilled per REQ-016) and ptr <= (g+1) mod NUM_FU.
REQ-020 SHALL leave ptr unchanged in any cycle with no grant.
REQ-021 SHALL register the broadcast outputs: at the grant edge, cdb_valid <= 1, cdb_reg_tag/cdb_reg_value <= held tag/value, cdb_fu_idx <= g.
REQ-022 SHALL, at an edge with no grant, set cdb_valid <= 0, cdb_reg_tag <= 0, cdb_reg_value <= 0 and cdb_fu_idx <= 0, so the idle bus always shows tag 0.
REQ-023 SHALL have latency as follows: a result accepted at edge k is broadcast at the earliest after edge k+1, i.e. valid during cycle k+1..k+2.
REQ-024 SHALL sustain one broadcast per cycle when any port holds a result; no bubble between consecutive grants.
REQ-025 SHALL, when squash = 1 at an edge: clear all held[i], ignore fu_valid, force cdb outputs to idle per REQ-022, and leave ptr unchanged.
REQ-026 SHALL keep each port's results in order, since a port holds at most one entry; no result is lost or duplicated absent squash.
REQ-027 SHALL use a NUM_FU-bit state count of held ports (sum of held[i]); no overflow is possible.

Reset
REQ-028 SHALL, while reset = 0 (asynchronous), force held[*] = 0, ptr = 0, cdb_valid = 0, cdb_reg_tag = 0, cdb_reg_value = 0 and cdb_fu_idx = 0.
REQ-029 SHALL hold fu_ready at 0 while reset is asserted, and at all ones from the first cycle after reset deasserts.
REQ-030 SHALL discard held results when reset is asserted mid-operation; nothing is broadcast after release until new transfers occur.

Verification
REQ-031 Single result: port 1 offers tag 3, value 10 at edge k -> cdb_valid = 1, tag 3, value 10, idx 1 after edge k+1; idle (valid 0, tag 0) after edge k+2.
REQ-032 Contention: ports 0, 1, 2 and 3 each offer tags 4, 5, 6 and 7 at the same edge -> broadcasts on four consecutive cycles in order 4, 5, 6, 7, then ptr = 0.
REQ-033 Fairness: port 0 offers continuously and port 2 offers once -> port 2 is broadcast within 2 grants; the grant order alternates 0, 2, 0, ...
REQ-034 Back-to-back on one port: port 3 holds valid high for 3 cycles with tags 1, 2, 3 -> fu_ready stays 1 and three consecutive broadcasts 1, 2, 3 appear.
REQ-035 Tag 0: port 0 offers tag 0, value 99 -> transfer completes and no broadcast occurs (cdb_valid stays 0).
REQ-036 Squash/reset: two results held and squash = 1 for one edge -> no broadcast follows and fu_ready = 0 during the squash cycle; repeat with reset = 0 mid-cycle -> outputs zero immediately, before the next edge.
